// File: rtl/trap_energy_picker_pkg.sv
// Shared types and constants for the trapezoid energy picker.
package trap_pkg;

  localparam int TRAP_DATA_WIDTH   = 32;
  localparam int TRAP_MAX_AVG_LOG2 = 4;
  // Accumulator holds up to 2^MAX_AVG_LOG2 sign-extended samples without overflow.
  localparam int ACC_WIDTH = TRAP_DATA_WIDTH + TRAP_MAX_AVG_LOG2;

  // Dropped-result counter saturates here.
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    REARM   = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    SUM     = 3'd3,
    HOLDOFF = 3'd4
  } trap_state_e;

endpackage

// File: rtl/trap_energy_picker_if.sv
// Stream bundle of the energy picker: trapezoid samples in, energy words out.
// Handshake: a sample is consumed on every clock with s_axis_tvalid=1 (no
// upstream backpressure); an output word transfers on a clock edge where
// m_axis_tvalid=1 and m_axis_tready=1, and tdata/tuser stay stable while
// tvalid=1 and tready=0.
interface trap_energy_picker_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tuser;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  // slave: the picker itself.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tvalid
  );

  // master: the environment feeding samples and accepting results.
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tvalid
  );
endinterface

// File: rtl/trap_energy_picker_axis_out_reg.sv
// One-deep output register; a new result arriving while the register is full
// and not being accepted is discarded and flagged on drop_o.
module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_user_i,
  input  logic                  tready_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tuser_o,
  output logic                  tvalid_o,
  output logic                  drop_o
);

  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tuser_q, tuser_d;
  logic                  tvalid_q, tvalid_d;
  logic                  can_load;

  // Load when empty or when the current word leaves this cycle; else hold.
  always_comb begin
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    can_load = !tvalid_q || tready_i;
    drop_o   = load_valid_i && !can_load;
    if (load_valid_i && can_load) begin
      tdata_d  = load_data_i;
      tuser_d  = load_user_i;
      tvalid_d = 1'b1;
    end else if (tvalid_q && tready_i) begin
      tvalid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign tdata_o  = tdata_q;
  assign tuser_o  = tuser_q;
  assign tvalid_o = tvalid_q;

endmodule

// File: rtl/trap_energy_picker.sv
// Pulse picker: threshold trigger with re-arm hysteresis, programmable delay to
// the flat-top, 2^N-sample average, one result per pulse into an output register.
module trap_energy_picker
  import trap_pkg::*;
#(
  parameter int DATA_WIDTH   = TRAP_DATA_WIDTH,
  parameter int MAX_AVG_LOG2 = TRAP_MAX_AVG_LOG2
) (
  input  logic                         clk,
  input  logic                         reset,
  trap_energy_picker_if.slave          axis,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  input  logic [13:0]                  peak_delay,
  input  logic [2:0]                   avg_log2,
  input  logic [13:0]                  holdoff,
  output logic [31:0]                  event_count,
  output logic [15:0]                  drop_count,
  output trap_state_e                  state_o
);

  localparam int ACC_W = DATA_WIDTH + MAX_AVG_LOG2;
  localparam int SC_W  = MAX_AVG_LOG2 + 1;

  trap_state_e             state_q, state_d;
  logic [13:0]             cnt_q, cnt_d;
  logic [SC_W-1:0]         sum_cnt_q, sum_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    flag_q, flag_d;
  logic [31:0]             event_q, event_d;
  logic [15:0]             drop_q;

  logic signed [DATA_WIDTH-1:0] samp;
  logic signed [ACC_W-1:0]      samp_ext, acc_new;
  logic                         below, flag_new;
  logic [2:0]                   n_log;
  logic [SC_W-1:0]              n_samples;
  logic [13:0]                  pd_eff;
  logic                         res_valid;
  logic [DATA_WIDTH-1:0]        res_data;
  logic                         drop;

  assign samp     = axis.s_axis_tdata;
  assign samp_ext = {{MAX_AVG_LOG2{samp[DATA_WIDTH-1]}}, samp};
  assign below    = samp < threshold;
  assign acc_new  = acc_q + samp_ext;
  assign flag_new = flag_q | below;
  assign n_log    = (avg_log2 > 3'(MAX_AVG_LOG2)) ? 3'(MAX_AVG_LOG2) : avg_log2;
  assign n_samples = SC_W'(1) << n_log;
  assign pd_eff   = (peak_delay == 14'd0) ? 14'd1 : peak_delay;
  assign res_data = DATA_WIDTH'(acc_new >>> n_log);

  // Next-state for the pulse FSM; only valid samples move anything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_cnt_d = sum_cnt_q;
    acc_d     = acc_q;
    flag_d    = flag_q;
    event_d   = event_q;
    res_valid = 1'b0;
    if (axis.s_axis_tvalid) begin
      unique case (state_q)
        REARM: if (below) state_d = ARMED;
        ARMED: if (!below) begin
          state_d = DELAY;
          event_d = event_q + 32'd1;
          cnt_d   = 14'd1;
          acc_d   = '0;
          flag_d  = 1'b0;
        end
        DELAY: begin
          // cnt_q equals the index of the current sample relative to the trigger.
          if (cnt_q >= pd_eff) begin
            acc_d     = acc_new;
            flag_d    = flag_new;
            sum_cnt_d = SC_W'(1);
            if (n_samples == SC_W'(1)) res_valid = 1'b1;
            else                       state_d   = SUM;
          end else begin
            cnt_d = cnt_q + 14'd1;
          end
        end
        SUM: begin
          acc_d     = acc_new;
          flag_d    = flag_new;
          sum_cnt_d = sum_cnt_q + SC_W'(1);
          if (sum_cnt_q + SC_W'(1) >= n_samples) res_valid = 1'b1;
        end
        HOLDOFF: begin
          cnt_d = cnt_q + 14'd1;
          if (cnt_q + 14'd1 >= holdoff) state_d = REARM;
        end
        default: state_d = REARM;
      endcase
      if (res_valid) begin
        cnt_d   = 14'd0;
        state_d = (holdoff == 14'd0) ? REARM : HOLDOFF;
      end
    end
  end

  // FSM, counters and accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= REARM;
      cnt_q     <= '0;
      sum_cnt_q <= '0;
      acc_q     <= '0;
      flag_q    <= 1'b0;
      event_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_cnt_q <= sum_cnt_d;
      acc_q     <= acc_d;
      flag_q    <= flag_d;
      event_q   <= event_d;
    end
  end

  // Saturating count of results discarded by a full output register.
  always_ff @(posedge clk) begin
    if (reset)                        drop_q <= '0;
    else if (drop && drop_q != DROP_MAX) drop_q <= drop_q + 16'd1;
  end

  axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (res_valid),
    .load_data_i  (res_data),
    .load_user_i  (flag_new),
    .tready_i     (axis.m_axis_tready),
    .tdata_o      (axis.m_axis_tdata),
    .tuser_o      (axis.m_axis_tuser),
    .tvalid_o     (axis.m_axis_tvalid),
    .drop_o       (drop)
  );

  assign event_count = event_q;
  assign drop_count  = drop_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_trap_energy_picker.sv
// Directed bench for trap_energy_picker with an output scoreboard.
module tb_trap_energy_picker;
  import trap_pkg::*;

  localparam int DW = 32;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trap_energy_picker_if #(.DATA_WIDTH(DW)) bus ();

  logic [DW-1:0] threshold;
  logic [13:0]   peak_delay;
  logic [2:0]    avg_log2;
  logic [13:0]   holdoff;
  logic [31:0]   event_count;
  logic [15:0]   drop_count;
  trap_state_e   state;

  trap_energy_picker #(.DATA_WIDTH(DW), .MAX_AVG_LOG2(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .axis        (bus),
    .threshold   (threshold),
    .peak_delay  (peak_delay),
    .avg_log2    (avg_log2),
    .holdoff     (holdoff),
    .event_count (event_count),
    .drop_count  (drop_count),
    .state_o     (state)
  );

  // Scoreboard: {tuser, tdata}.
  logic [DW:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ramp[4] = '{150, 200, 300, 400};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: one valid sample per clock, optionally followed by a gap.
  task automatic send(input int s);
    bus.s_axis_tdata  = DW'(s);
    bus.s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic send_gap(input int s);
    send(s);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic user, input int data);
    exp_q.push_back({user, DW'(data)});
  endtask

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b0;
    threshold  = DW'(100);
    peak_delay = 14'd4;
    avg_log2   = 3'd2;
    holdoff    = 14'd0;
    reset      = 1'b1;

    // Monitor: compare every transfer against the head of the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (!reset && bus.m_axis_tvalid && bus.m_axis_tready) begin
          n_checks++;
          assert (exp_q.size() != 0)
          else begin
            n_fail++;
            $error("FAIL out_unexpected: observed %0h expected none",
                   {bus.m_axis_tuser, bus.m_axis_tdata});
          end
          if (exp_q.size() != 0)
            chk("out_word", {31'd0, bus.m_axis_tuser, bus.m_axis_tdata}, {31'd0, exp_q.pop_front()});
        end
      end
    join_none

    // Reset state.
    idle(3);
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 0);
    chk("rst_tdata",  64'(bus.m_axis_tdata), 0);
    chk("rst_tuser",  64'(bus.m_axis_tuser), 0);
    chk("rst_event",  64'(event_count), 0);
    chk("rst_drop",   64'(drop_count), 0);
    chk("rst_state",  64'(state), 64'(REARM));
    reset = 1'b0;
    bus.m_axis_tready = 1'b1;

    // Basic pick with latency check.
    send(0); send(0);
    foreach (ramp[i]) send(ramp[i]);
    send(500); send(500); send(500);
    chk("basic_early", 64'(bus.m_axis_tvalid), 0);
    push(1'b0, 500);
    send(500);
    chk("basic_latency", 64'(bus.m_axis_tvalid), 1);
    chk("basic_event", 64'(event_count), 1);
    send(0);

    // Short pulse: a dip inside the window sets tuser.
    send(0); send(150); send(200); send(300); send(400);
    send(500); send(500); send(50);
    push(1'b1, 387);
    send(500);
    send(0);
    chk("short_event", 64'(event_count), 2);

    // Backpressure: first result held, second dropped.
    bus.m_axis_tready = 1'b0;
    foreach (ramp[i]) send(ramp[i]);
    push(1'b0, 500);
    repeat (4) send(500);
    send(0); send(0);
    foreach (ramp[i]) send(ramp[i]);
    repeat (4) send(600);
    send(0);
    chk("bp_drop",   64'(drop_count), 1);
    chk("bp_event",  64'(event_count), 4);
    chk("bp_tvalid", 64'(bus.m_axis_tvalid), 1);
    chk("bp_held",   64'(bus.m_axis_tdata), 500);
    bus.m_axis_tready = 1'b1;
    idle(3);
    chk("bp_drained", 64'(bus.m_axis_tvalid), 0);

    // Gapped valid plus holdoff.
    holdoff = 14'd10;
    foreach (ramp[i]) send_gap(ramp[i]);
    send_gap(500); send_gap(500); send_gap(500);
    push(1'b0, 500);
    send_gap(500);
    chk("gap_event", 64'(event_count), 5);
    repeat (4) send(0);
    send(150);
    repeat (5) send(0);
    send(150); send(150);
    chk("holdoff_ignored", 64'(event_count), 5);
    holdoff = 14'd0;
    send(0);
    send(150);
    chk("holdoff_retrig", 64'(event_count), 6);
    send(200); send(300); send(400);
    send(500); send(500); send(500);
    push(1'b0, 500);
    send(500);
    send(0);

    // Negative levels, clamped avg_log2, peak_delay of zero.
    threshold  = DW'(-300);
    peak_delay = 14'd0;
    avg_log2   = 3'd7;
    send(-400);
    send(-250);
    send(-184);
    repeat (14) send(-200);
    chk("neg_early", 64'(bus.m_axis_tvalid), 0);
    push(1'b0, -199);
    send(-200);
    chk("neg_latency", 64'(bus.m_axis_tvalid), 1);
    chk("neg_event", 64'(event_count), 7);
    send(-400);

    // Reset mid-SUM with a pending result.
    threshold  = DW'(100);
    peak_delay = 14'd4;
    avg_log2   = 3'd2;
    idle(2);
    bus.m_axis_tready = 1'b0;
    send(0);
    foreach (ramp[i]) send(ramp[i]);
    repeat (4) send(500);
    chk("pend_tvalid", 64'(bus.m_axis_tvalid), 1);
    send(0);
    foreach (ramp[i]) send(ramp[i]);
    send(500); send(500);
    chk("pre_rst_state", 64'(state), 64'(SUM));
    reset = 1'b1;
    idle(1);
    chk("mid_rst_tvalid", 64'(bus.m_axis_tvalid), 0);
    chk("mid_rst_event",  64'(event_count), 0);
    chk("mid_rst_drop",   64'(drop_count), 0);
    chk("mid_rst_state",  64'(state), 64'(REARM));
    reset = 1'b0;
    bus.m_axis_tready = 1'b1;
    repeat (5) send(150);
    chk("high_no_trig", 64'(event_count), 0);
    send(50);
    send(150);
    chk("rearm_trig", 64'(event_count), 1);
    idle(3);
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_energy_picker.md
Name: trap_energy_picker

Overview:
- Sits directly downstream of the trapezoidal shaper and consumes its 32-bit signed trapezoid stream.
- Detects each pulse by threshold crossing with re-arm hysteresis, waits a programmable delay to reach the flat-top, then averages 2^avg_log2 flat-top samples.
- Emits one energy word per pulse through a one-deep AXI-Stream output register with a ready handshake.
- Provides an event counter and a dropped-result counter for the PS.

Parameters:
- DATA_WIDTH, 32, width of the input trapezoid samples and of the output energy word.
- MAX_AVG_LOG2, 4, largest allowed averaging exponent; the accumulator is DATA_WIDTH+MAX_AVG_LOG2 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- s_axis_tdata  in  DATA_WIDTH  signed trapezoid sample.
- s_axis_tvalid  in  1  sample qualifier. Only valid samples advance any counter or state.
- threshold  in  DATA_WIDTH  signed trigger level.
- peak_delay  in  14  valid samples from trigger to first summed sample (0 treated as 1).
- avg_log2  in  3  averaging exponent; values above MAX_AVG_LOG2 clamp to MAX_AVG_LOG2.
- holdoff  in  14  valid samples ignored after the summing window.
- m_axis_tdata  out  DATA_WIDTH  signed averaged flat-top energy.
- m_axis_tuser  out  1  short-pulse flag: a sample inside the window was below threshold.
- m_axis_tvalid  out  1  result pending.
- m_axis_tready  in  1  consumer accept.
- event_count  out  32  number of triggers, wraps.
- drop_count  out  16  results lost because the output was full; saturates at 0xFFFF.

Behaviour:
- Reset: state is REARM. All counters, the accumulator and the flag are 0. m_axis_tdata=0, m_axis_tuser=0, m_axis_tvalid=0, event_count=0, drop_count=0.
- Configuration inputs are sampled at their point of use. Software changes them only while the stream is idle; behaviour on a mid-pulse change is not guaranteed beyond no lock-up.
- Trigger sample is index 0. Window indices are peak_delay .. peak_delay+N-1, where N=2^avg_log2 after clamping.
- FSM (transitions only on s_axis_tvalid=1):
  - REARM: sample < threshold -> ARMED.
  - ARMED: sample >= threshold -> DELAY; event_count+1; delay counter=1; accumulator=0; flag=0.
  - DELAY: counter+1 per sample. The sample at which counter reaches peak_delay is accumulated and the state moves to SUM with sum count=1. If N=1 the window completes on that same sample.
  - SUM: accumulate with sign extension; any sample < threshold sets the flag. On the Nth sample, finish the window: go to HOLDOFF, or to REARM if holdoff=0.
  - HOLDOFF: count holdoff samples, then REARM. Triggers are ignored here.
- Result: accumulator >>> avg_log2 (arithmetic shift), truncated to DATA_WIDTH. It always fits, so no saturation is needed.
- Latency: m_axis_tvalid rises the cycle after the Nth window sample is accepted.
- Output register:
  - Holds tdata/tuser stable while tvalid=1 and tready=0.
  - Clears tvalid on a cycle with tvalid&&tready.
  - New result, register empty or being accepted that same cycle: load it. Accept and reload in the same cycle keeps tvalid=1 with the new data.
  - New result while the register is full and not accepted: discard the new result; drop_count+1, saturating.
- s_axis_tvalid=0 cycles freeze the FSM and its counters; the output handshake still operates.
- Reset asserted mid-pulse or with a result pending: everything returns to reset values the next cycle, and the pending result is lost.
- Input starting above threshold after reset: no trigger until a below-threshold sample arms the FSM.

Decomposition:
- Package trap_pkg holds:
  - the state enum (REARM, ARMED, DELAY, SUM, HOLDOFF);
  - localparam ACC_WIDTH = DATA_WIDTH + MAX_AVG_LOG2;
  - the DROP_MAX constant.
- One natural sub-module, axis_out_reg: the one-deep output register with the drop signal. The FSM and accumulator stay in the top level.

Test Plan:
- Basic pick: threshold=100, peak_delay=4, avg_log2=2, holdoff=0, tready=1. Stream 0,0,150,200,300,400,500,500,500,500,0. Expect tdata=500, tuser=0, tvalid high one cycle after the 4th 500, event_count=1.
- Short pulse: same configuration, stream 0,150,200,300,400,500,500,50,500,0. Expect tdata=387 ((500+500+50+500)>>2, floor of 387.5), tuser=1.
- Backpressure/drop: tready=0, two qualifying pulses separated by below-threshold samples, both with flat-top 500. Expect the first result held stable, drop_count=1, event_count=2. Raise tready -> one transfer of 500.
- Gapped valid and holdoff: the basic pulse with tvalid deasserted every other cycle gives the identical result. With holdoff=10, a second crossing 5 valid samples after the window is ignored (event_count unchanged); a crossing after 12 valid samples plus a below-threshold sample triggers.
- Negative/edge: avg_log2=7 (clamped to 4), flat-top -200 with threshold=-300 and baseline -400. Expect tdata=-200 (0xFFFFFF38). peak_delay=0 behaves as peak_delay=1.
- Reset mid-SUM with a pending result: tvalid=0 and all counts 0 next cycle. An input held at 150 does not trigger until a sample below 100.
